// File: rtl/hyperspace_stream_ctrl_if.sv
// hyperspace_stream_ctrl_if: valid/ready stream bundle with optional last marker.
//   valid  source -> sink  beat present
//   ready  sink -> source  sink accepts the beat
//   data   source -> sink  beat payload, W bits
//   last   source -> sink  final beat of a frame
// Modports: master = stream source, slave = stream sink.
interface hyperspace_stream_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/hyperspace_stream_ctrl.sv
// hyperspace_stream_ctrl: per-frame sequencer between the pad byte stream and the
// HyperSpace DSP core, and between the core's word stream and the pads.
// Optional feature macro: HYPERSPACE_LAST_CHECK_EN (pad last-marker checking).
// Ports:
//   clock, RSTB        clock; synchronous active-high reset
//   i_start, i_abort   one-cycle run control pulses
//   i_num_frames       frames per run (0 = continuous), sampled on start
//   s_in  (slave)      pad-side input stream
//   c_in  (master)     core input stream, last regenerated from the beat count
//   c_out (slave)      core output stream (last unused)
//   m_out (master)     pad-side output stream, last generated from the beat count
//   o_busy             run in FILL/DRAIN
//   o_done             one-cycle pulse at run completion
//   o_frame_cnt        frames completed in the current run (saturating)
//   o_err_timeout      sticky watchdog error
//   o_err_last         sticky pad last-marker mismatch (0 when feature absent)
module hyperspace_stream_ctrl #(
    parameter int unsigned IN_W           = 8,
    parameter int unsigned OUT_W          = 16,
    parameter int unsigned IN_FRAME_LEN   = 2048,
    parameter int unsigned OUT_FRAME_LEN  = 1536,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                           clock,
    input  logic                           RSTB,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [7:0]                     i_num_frames,
    hyperspace_stream_ctrl_if.slave        s_in,
    hyperspace_stream_ctrl_if.master       c_in,
    hyperspace_stream_ctrl_if.slave        c_out,
    hyperspace_stream_ctrl_if.master       m_out,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [7:0]                     o_frame_cnt,
    output logic                           o_err_timeout,
    output logic                           o_err_last
);

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_in_cnt, w_in_cnt_nxt;
    logic [CNT_W-1:0] r_out_cnt, w_out_cnt_nxt;
    logic [CNT_W-1:0] r_wd, w_wd_nxt;
    logic             r_out_done, w_out_done_nxt;
    logic [7:0]       r_num_frames, w_num_frames_nxt;
    logic [7:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic             r_err_timeout, w_err_timeout_nxt;
    logic             r_err_last, w_err_last_nxt;

    logic             w_busy;
    logic             w_in_open;
    logic             w_out_open;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_out_last_hs;
    logic [8:0]       w_fc_inc;
    logic             w_unused;

    assign w_busy     = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign w_in_open  = (r_state == ST_FILL);
    // Output frame is held once complete so it cannot run ahead of the input frame.
    assign w_out_open = w_busy && !r_out_done;

    // Input pass-through; core-side last comes only from our own beat count.
    assign s_in.ready = w_in_open & c_in.ready;
    assign c_in.valid = w_in_open & s_in.valid;
    assign c_in.data  = IN_W'(s_in.data);
    assign c_in.last  = w_in_open & (r_in_cnt == IN_LAST);

    // Output pass-through with generated last.
    assign c_out.ready = w_out_open & m_out.ready;
    assign m_out.valid = w_out_open & c_out.valid;
    assign m_out.data  = OUT_W'(c_out.data);
    assign m_out.last  = w_out_open & (r_out_cnt == OUT_LAST);

    assign w_in_hs       = w_in_open & s_in.valid & c_in.ready;
    assign w_out_hs      = w_out_open & c_out.valid & m_out.ready;
    assign w_out_last_hs = w_out_hs & (r_out_cnt == OUT_LAST);
    assign w_fc_inc      = {1'b0, r_frame_cnt} + 9'd1;

`ifdef HYPERSPACE_LAST_CHECK_EN
    assign w_unused = c_out.last;
`else
    assign w_unused = c_out.last ^ s_in.last;
`endif

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            r_state       <= ST_IDLE;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_wd          <= '0;
            r_out_done    <= 1'b0;
            r_num_frames  <= 8'd0;
            r_frame_cnt   <= 8'd0;
            r_err_timeout <= 1'b0;
            r_err_last    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_cnt      <= w_in_cnt_nxt;
            r_out_cnt     <= w_out_cnt_nxt;
            r_wd          <= w_wd_nxt;
            r_out_done    <= w_out_done_nxt;
            r_num_frames  <= w_num_frames_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_err_last    <= w_err_last_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_in_cnt_nxt      = r_in_cnt;
        w_out_cnt_nxt     = r_out_cnt;
        w_wd_nxt          = r_wd;
        w_out_done_nxt    = r_out_done;
        w_num_frames_nxt  = r_num_frames;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_err_timeout_nxt = r_err_timeout;
        w_err_last_nxt    = r_err_last;

        if (w_out_hs) begin
            if (w_out_last_hs) begin
                w_out_cnt_nxt  = '0;
                w_out_done_nxt = 1'b1;
            end else begin
                w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
            end
        end

        if (w_in_hs) begin
`ifdef HYPERSPACE_LAST_CHECK_EN
            if (s_in.last != (r_in_cnt == IN_LAST)) begin
                w_err_last_nxt = 1'b1;
            end
`endif
            if (r_in_cnt == IN_LAST) begin
                w_in_cnt_nxt = '0;
                w_state_nxt  = ST_DRAIN;
            end else begin
                w_in_cnt_nxt = r_in_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt       = ST_FILL;
                    w_num_frames_nxt  = i_num_frames;
                    w_frame_cnt_nxt   = 8'd0;
                    w_err_timeout_nxt = 1'b0;
                    w_err_last_nxt    = 1'b0;
                    w_in_cnt_nxt      = '0;
                    w_out_cnt_nxt     = '0;
                    w_wd_nxt          = '0;
                    w_out_done_nxt    = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Frame closes once the matching output frame has fully left.
                if (r_out_done || w_out_last_hs) begin
                    w_out_done_nxt  = 1'b0;
                    w_frame_cnt_nxt = (r_frame_cnt == 8'hFF) ? r_frame_cnt : w_fc_inc[7:0];
                    if ((r_num_frames != 8'd0) && ({1'b0, r_num_frames} == w_fc_inc)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: ;
        endcase

        // Watchdog counts consecutive busy cycles with no handshake on any stream.
        if (w_busy) begin
            if (w_in_hs || w_out_hs) begin
                w_wd_nxt = '0;
            end else if (r_wd == WD_LAST) begin
                w_wd_nxt          = '0;
                w_err_timeout_nxt = 1'b1;
                w_state_nxt       = ST_ERR;
            end else begin
                w_wd_nxt = r_wd + CNT_W'(1);
            end
        end

        // Abort drops the run without a done pulse; error flags survive.
        if (i_abort && (w_busy || (r_state == ST_ERR))) begin
            w_state_nxt    = ST_IDLE;
            w_in_cnt_nxt   = '0;
            w_out_cnt_nxt  = '0;
            w_wd_nxt       = '0;
            w_out_done_nxt = 1'b0;
        end
    end

    assign o_busy        = w_busy;
    assign o_done        = (r_state == ST_DONE);
    assign o_frame_cnt   = r_frame_cnt;
    assign o_err_timeout = r_err_timeout;
`ifdef HYPERSPACE_LAST_CHECK_EN
    assign o_err_last    = r_err_last;
`else
    assign o_err_last    = 1'b0;
`endif

endmodule

// File: tb/tb_hyperspace_stream_ctrl.sv
// tb_hyperspace_stream_ctrl: directed bench for hyperspace_stream_ctrl with a
// pad source, a frame-buffering core model and a pad sink.
module tb_hyperspace_stream_ctrl;

    localparam int unsigned IN_W    = 8;
    localparam int unsigned OUT_W   = 16;
    localparam int          IN_LEN  = 2048;
    localparam int          OUT_LEN = 1536;
    localparam int unsigned TMO     = 100;

    logic       clock = 1'b0;
    logic       RSTB;
    logic       start;
    logic       abort;
    logic [7:0] num_frames;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;
    logic       err_timeout;
    logic       err_last;

    always #5 clock = ~clock;

    hyperspace_stream_ctrl_if #(.W(IN_W))  s_in_if ();
    hyperspace_stream_ctrl_if #(.W(IN_W))  c_in_if ();
    hyperspace_stream_ctrl_if #(.W(OUT_W)) c_out_if ();
    hyperspace_stream_ctrl_if #(.W(OUT_W)) m_out_if ();

    hyperspace_stream_ctrl #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .clock         (clock),
        .RSTB          (RSTB),
        .i_start       (start),
        .i_abort       (abort),
        .i_num_frames  (num_frames),
        .s_in          (s_in_if),
        .c_in          (c_in_if),
        .c_out         (c_out_if),
        .m_out         (m_out_if),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_cnt   (frame_cnt),
        .o_err_timeout (err_timeout),
        .o_err_last    (err_last)
    );

    typedef struct {
        logic [7:0] nf;
        int         exp_bytes;
        int         exp_words;
        int         exp_lasts;
        int         exp_fc;
        int         exp_done;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0, last_hs_cyc = 0, err_cyc = -1;
    int n_in = 0, n_out = 0, n_last_out = 0, n_done = 0, mon_bad = 0;
    int mon_in_pos = 0, mon_out_pos = 0;
    int tx_pos = 0, tx_val = 0, credit = 0, wval = 0, last_pos = IN_LEN - 1;
    bit rnd = 1'b0, pad_en = 1'b0, core_en = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit coin();
        return !rnd || ($urandom_range(7, 0) != 0);
    endfunction

    task automatic drive();
        s_in_if.valid  = pad_en && coin();
        s_in_if.data   = 8'(tx_val * 37 + 11);
        s_in_if.last   = (tx_pos == last_pos);
        c_in_if.ready  = coin();
        c_out_if.valid = core_en && (credit > 0) && coin();
        c_out_if.data  = 16'(wval * 40503 + 7);
        c_out_if.last  = 1'b0;
        m_out_if.ready = coin();
    endtask

    // One clock: monitor at the falling edge, then update source/core/sink models.
    task automatic step();
        logic hs_s, hs_c, hs_co, hs_m;
        @(negedge clock);
        hs_s  = s_in_if.valid && s_in_if.ready;
        hs_c  = c_in_if.valid && c_in_if.ready;
        hs_co = c_out_if.valid && c_out_if.ready;
        hs_m  = m_out_if.valid && m_out_if.ready;
        if (hs_s != hs_c) mon_bad++;
        if (hs_co != hs_m) mon_bad++;
        if (hs_c) begin
            n_in++;
            if (c_in_if.data != s_in_if.data) mon_bad++;
            if (c_in_if.last != (mon_in_pos == IN_LEN - 1)) mon_bad++;
            mon_in_pos = (mon_in_pos == IN_LEN - 1) ? 0 : mon_in_pos + 1;
        end
        if (hs_m) begin
            n_out++;
            if (m_out_if.last) n_last_out++;
            if (m_out_if.data != c_out_if.data) mon_bad++;
            if (m_out_if.last != (mon_out_pos == OUT_LEN - 1)) mon_bad++;
            mon_out_pos = (mon_out_pos == OUT_LEN - 1) ? 0 : mon_out_pos + 1;
        end
        if (done) n_done++;
        if (!busy) begin
            mon_in_pos  = 0;
            mon_out_pos = 0;
        end
        if (hs_s || hs_c || hs_co || hs_m) last_hs_cyc = cyc;
        if (err_timeout && err_cyc < 0) err_cyc = cyc;
        @(posedge clock);
        cyc++;
        #1;
        if (hs_c && c_in_if.last) credit += OUT_LEN;
        if (hs_co) begin
            credit--;
            wval++;
        end
        if (abort || RSTB) credit = 0;
        if (hs_s) begin
            tx_val++;
            tx_pos = (tx_pos == IN_LEN - 1) ? 0 : tx_pos + 1;
        end
        if (start) tx_pos = 0;
        start = 1'b0;
        abort = 1'b0;
        drive();
    endtask

    task automatic run_to_done(input int budget);
        int d0;
        d0 = n_done;
        for (int k = 0; k < budget && n_done == d0; k++) step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t vecs[2];
        int   d_in, d_out, d_last, d_done, d_bad;

        vecs[0] = '{nf: 8'd1, exp_bytes: IN_LEN,     exp_words: OUT_LEN,     exp_lasts: 1, exp_fc: 1, exp_done: 1};
        vecs[1] = '{nf: 8'd3, exp_bytes: 3 * IN_LEN, exp_words: 3 * OUT_LEN, exp_lasts: 3, exp_fc: 3, exp_done: 1};

        RSTB = 1'b1; start = 1'b0; abort = 1'b0; num_frames = 8'd0;
        pad_en = 1'b1;
        drive();
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", {err_timeout, err_last}, 0);
        chk("rst_gating", {s_in_if.ready, c_in_if.valid, m_out_if.valid, c_out_if.ready}, 0);
        RSTB = 1'b0;
        step();

        // Table-driven runs with random throttling on every stream.
        rnd = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_in = n_in; d_out = n_out; d_last = n_last_out; d_done = n_done; d_bad = mon_bad;
            num_frames = vecs[i].nf;
            start = 1'b1;
            step();
            run_to_done(int'(vecs[i].nf) * 12000);
            repeat (10) step();
            chk("run_bytes", n_in - d_in, vecs[i].exp_bytes);
            chk("run_words", n_out - d_out, vecs[i].exp_words);
            chk("run_out_lasts", n_last_out - d_last, vecs[i].exp_lasts);
            chk("run_done_pulses", n_done - d_done, vecs[i].exp_done);
            chk("run_frame_cnt", frame_cnt, vecs[i].exp_fc);
            chk("run_stream_bad", mon_bad - d_bad, 0);
            chk("idle_refuse", {busy, s_in_if.ready, c_in_if.valid}, 0);
        end
        rnd = 1'b0;

        // Abort at in_cnt=1000, then a clean full frame.
        d_done = n_done;
        num_frames = 8'd1;
        start = 1'b1;
        step();
        d_in = n_in;
        for (int k = 0; k < 3000 && (n_in - d_in) < 1000; k++) step();
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_in_if.ready, 0);
        repeat (5) step();
        chk("abort_no_done", n_done - d_done, 0);
        d_in = n_in; d_out = n_out; d_bad = mon_bad;
        start = 1'b1;
        step();
        run_to_done(12000);
        chk("rerun_bytes", n_in - d_in, IN_LEN);
        chk("rerun_words", n_out - d_out, OUT_LEN);
        chk("rerun_frame_cnt", frame_cnt, 1);
        chk("rerun_stream_bad", mon_bad - d_bad, 0);

        // Watchdog: the core withholds its output after the fill.
        core_en = 1'b0;
        err_cyc = -1;
        start = 1'b1;
        step();
        for (int k = 0; k < 5000 && err_cyc < 0; k++) step();
        chk("tmo_latency", err_cyc - last_hs_cyc, int'(TMO) + 1);
        chk("tmo_busy", busy, 0);
        core_en = 1'b1;
        drive();
        repeat (2) step();
        chk("err_gating", {m_out_if.valid, c_out_if.ready, s_in_if.ready}, 0);
        chk("err_core_valid", c_out_if.valid, 1);
        abort = 1'b1;
        step();
        chk("err_abort_busy", busy, 0);
        chk("err_flag_kept", err_timeout, 1);

        // Reset mid-frame, then a continuous run.
        num_frames = 8'd0;
        start = 1'b1;
        step();
        chk("start_clears_err", err_timeout, 0);
        d_in = n_in;
        for (int k = 0; k < 2000 && (n_in - d_in) < 500; k++) step();
        RSTB = 1'b1;
        step();
        chk("midrst_status", {busy, done, err_timeout, err_last}, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_gating", {s_in_if.ready, c_in_if.valid, m_out_if.valid, c_out_if.ready}, 0);
        RSTB = 1'b0;
        step();
        d_done = n_done; d_bad = mon_bad;
        start = 1'b1;
        step();
        for (int k = 0; k < 30000 && frame_cnt < 8'd5; k++) step();
        chk("cont_frame_cnt", frame_cnt, 5);
        repeat (3) step();
        chk("cont_busy", busy, 1);
        chk("cont_no_done", n_done - d_done, 0);
        chk("cont_stream_bad", mon_bad - d_bad, 0);
        abort = 1'b1;
        step();

        // Pad last marker one byte early.
        last_pos = IN_LEN - 2;
        num_frames = 8'd1;
        d_done = n_done; d_bad = mon_bad;
        start = 1'b1;
        step();
        run_to_done(12000);
        repeat (2) step();
`ifdef HYPERSPACE_LAST_CHECK_EN
        chk("err_last", err_last, 1);
`else
        chk("err_last", err_last, 0);
`endif
        chk("last_frame_done", n_done - d_done, 1);
        chk("last_stream_bad", mon_bad - d_bad, 0);
        last_pos = IN_LEN - 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
